// File: rtl/m_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM encoding, NOP word
// and the sequential PC increment.
package m_fetch_stage_pkg;

    localparam int XLEN = 32;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DROP     = 2'd2
    } fetch_state_e;

    // A bubble in IF/ID carries this instruction word
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch step in bytes
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    // Next sequential PC; wraps modulo 2^32
    function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/m_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: loads a new instruction when enabled, loads a
// bubble when enabled and cleared, and holds its contents when disabled.
module m_ifid_reg
    import m_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pcplus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            valid_q, valid_d;

    // Select hold, bubble or new instruction for the next cycle
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (en) begin
            if (clr) begin
                instr_d   = NOP_INSTR;
                pcplus4_d = '0;
                valid_d   = 1'b0;
            end else begin
                instr_d   = instr_i;
                pcplus4_d = pcplus4_i;
                valid_d   = 1'b1;
            end
        end
    end

    // Register update; reset leaves a bubble in the stage
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/m_fetch_stage.sv
// Instruction fetch stage: owns the PC and a three-state fetch FSM that
// talks to a variable-latency instruction memory. A one-entry buffer keeps
// a response that arrives while the front end is stalled; a pending
// register remembers a redirect target while an old request is drained.
module m_fetch_stage
    import m_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pcplus4_q, buf_pcplus4_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  deliver_pcplus4;
    logic         bubble;

    // Redirect decode: a stalled decode stage cannot redirect; jump wins over branch
    always_comb begin
        redirect = (pcsrcD | jumpD) & ~stallD;
        target   = jumpD ? pcjumpD : pcbranchD;
        pc_plus4 = pc_next_seq(pc_q);
    end

    // No request while a response is parked in the buffer or during reset
    assign imem_req  = ~reset & (state_q != BUFFERED);
    assign imem_addr = pc_q;

    // Next-state, PC, buffer and pending-target logic
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_d          = pend_q;
        buf_instr_d     = buf_instr_q;
        buf_pcplus4_d   = buf_pcplus4_q;
        deliver         = 1'b0;
        deliver_instr   = NOP_INSTR;
        deliver_pcplus4 = '0;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = DROP;
                    end
                end else if (imem_ready) begin
                    // A decode stall also parks the word so it is never lost
                    if (stallF | stallD) begin
                        buf_instr_d   = imem_rdata;
                        buf_pcplus4_d = pc_plus4;
                        state_d       = BUFFERED;
                    end else begin
                        pc_d            = pc_plus4;
                        deliver         = 1'b1;
                        deliver_instr   = imem_rdata;
                        deliver_pcplus4 = pc_plus4;
                    end
                end
            end
            BUFFERED: begin
                if (redirect) begin
                    pc_d          = target;
                    buf_instr_d   = '0;
                    buf_pcplus4_d = '0;
                    state_d       = FETCH;
                end else if (~stallF & ~stallD) begin
                    deliver         = 1'b1;
                    deliver_instr   = buf_instr_q;
                    deliver_pcplus4 = buf_pcplus4_q;
                    pc_d            = pc_plus4;
                    buf_instr_d     = '0;
                    buf_pcplus4_d   = '0;
                    state_d         = FETCH;
                end
            end
            DROP: begin
                // The outstanding response is thrown away; the latest target wins
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_q;
                    pend_d  = '0;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Fetch state registers; reset abandons any parked or pending data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pend_q        <= '0;
            buf_instr_q   <= '0;
            buf_pcplus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            buf_instr_q   <= buf_instr_d;
            buf_pcplus4_q <= buf_pcplus4_d;
        end
    end

    // Memory wait states and redirects both appear to decode as NOPs
    assign bubble = redirect | ~deliver;

    m_ifid_reg u_ifid (
        .clk       (clk),
        .reset     (reset),
        .en        (~stallD),
        .clr       (bubble),
        .instr_i   (deliver_instr),
        .pcplus4_i (deliver_pcplus4),
        .instr_o   (instrD),
        .pcplus4_o (pcplus4D),
        .valid_o   (validD)
    );

endmodule

// File: tb/tb_m_fetch_stage.sv
// Bench for m_fetch_stage: directed scenarios followed by randomized traffic.
// Reference model: the decode stage must see the program stream in order,
// starting at the reset PC, advancing by 4 per delivered instruction and
// restarting at the target of every accepted redirect.
module tb_m_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        stallF     = 1'b0;
    logic        stallD     = 1'b0;
    logic        pcsrcD     = 1'b0;
    logic [31:0] pcbranchD  = '0;
    logic        jumpD      = 1'b0;
    logic [31:0] pcjumpD    = '0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;

    int checks     = 0;
    int failures   = 0;
    int deliveries = 0;

    // Scoreboard: address of the next instruction decode must receive
    logic [31:0] exp_q[$];

    // Monitor history (values seen during the previous cycle)
    logic        p_req   = 1'b0;
    logic [31:0] p_addr  = '0;
    logic [31:0] p_instr = '0;
    logic [31:0] p_pc4   = '0;
    logic        p_valid = 1'b0;
    logic [31:0] mon_a;

    // Random stimulus scratch
    logic        r_rst, r_sF, r_sD, r_ps, r_jp;
    logic [31:0] r_pb, r_pj;

    always #5 clk = ~clk;

    m_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stallF     (stallF),
        .stallD     (stallD),
        .pcsrcD     (pcsrcD),
        .pcbranchD  (pcbranchD),
        .jumpD      (jumpD),
        .pcjumpD    (pcjumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
    );

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
        else                        t = $urandom & 32'h0000_0FFC;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then return just after
    // the rising edge that consumed it. rmode: 0 random ready, 1 ready, 2 not ready.
    task automatic drive(input logic rst, input logic sF, input logic sD,
                         input logic ps, input logic [31:0] pb,
                         input logic jp, input logic [31:0] pj, input int rmode);
        @(negedge clk);
        reset     = rst;
        stallF    = sF;
        stallD    = sD;
        pcsrcD    = ps;
        pcbranchD = pb;
        jumpD     = jp;
        pcjumpD   = pj;
        imem_rdata = mem_word(imem_addr);
        case (rmode)
            0:       imem_ready = imem_req & ($urandom_range(2) != 0);
            1:       imem_ready = 1'b1;
            default: imem_ready = 1'b0;
        endcase
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else if ((ps | jp) && !sD) begin
            exp_q.delete();
            exp_q.push_back(jp ? pj : pb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int rmode);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rmode);
    endtask

    // Monitor: compares IF/ID after every rising edge against the scoreboard
    initial begin
        exp_q.push_back(RESET_PC);
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("reset_instrD", instrD, 32'h0);
                check("reset_pcplus4D", pcplus4D, 32'h0);
                checkb("reset_validD", validD, 1'b0);
                checkb("reset_imem_req", imem_req, 1'b0);
            end else begin
                if (p_req && !imem_ready)
                    check("addr_hold", imem_addr, p_addr);
                if (stallD) begin
                    check("hold_instrD", instrD, p_instr);
                    check("hold_pcplus4D", pcplus4D, p_pc4);
                    checkb("hold_validD", validD, p_valid);
                end else if (pcsrcD | jumpD) begin
                    checkb("redirect_validD", validD, 1'b0);
                    check("redirect_instrD", instrD, 32'h0);
                    check("redirect_pcplus4D", pcplus4D, 32'h0);
                end else if (validD) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_delivery: got pcplus4D %h with no expected entry", pcplus4D);
                    end else begin
                        mon_a = exp_q.pop_front();
                        check("deliver_instrD", instrD, mem_word(mon_a));
                        check("deliver_pcplus4D", pcplus4D, mon_a + 32'd4);
                        exp_q.push_back(mon_a + 32'd4);
                        deliveries++;
                    end
                end else begin
                    check("bubble_instrD", instrD, 32'h0);
                    check("bubble_pcplus4D", pcplus4D, 32'h0);
                end
            end
            p_req   = imem_req;
            p_addr  = imem_addr;
            p_instr = instrD;
            p_pc4   = pcplus4D;
            p_valid = validD;
        end
    end

    // Stimulus
    initial begin
        // Reset with memory responses offered; they must be ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        checkb("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);

        // Back-to-back fetches with memory always ready
        idle(1);
        checkb("seq_valid_1", validD, 1'b1);
        check("seq_instr_1", instrD, mem_word(32'h0));
        check("seq_pc4_1", pcplus4D, 32'h4);
        check("seq_addr_1", imem_addr, 32'h4);
        idle(1);
        check("seq_pc4_2", pcplus4D, 32'h8);
        check("seq_addr_2", imem_addr, 32'h8);
        idle(1);
        check("seq_pc4_3", pcplus4D, 32'hC);
        idle(1);
        check("seq_addr_4", imem_addr, 32'h10);

        // Response at 0x10 arrives during a full stall and is parked
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        checkb("buf_req_0", imem_req, 1'b0);
        check("buf_hold_pc4", pcplus4D, 32'h10);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        checkb("buf_req_2", imem_req, 1'b0);
        check("buf_addr_2", imem_addr, 32'h10);
        idle(1);
        check("buf_instr", instrD, mem_word(32'h10));
        check("buf_pc4", pcplus4D, 32'h14);
        check("buf_next_addr", imem_addr, 32'h14);
        checkb("buf_next_req", imem_req, 1'b1);

        // Taken branch while memory is ready
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1);
        checkb("br_bubble", validD, 1'b0);
        check("br_addr", imem_addr, 32'h100);
        idle(1);
        check("br_instr", instrD, mem_word(32'h100));
        check("br_pc4", pcplus4D, 32'h104);

        // Jump while the fetch at 0x20 is still outstanding
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1);
        check("jmp20_addr", imem_addr, 32'h20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 2);
        check("drop_addr_0", imem_addr, 32'h20);
        checkb("drop_req_0", imem_req, 1'b1);
        idle(2);
        idle(2);
        check("drop_addr_2", imem_addr, 32'h20);
        checkb("drop_req_2", imem_req, 1'b1);
        idle(1);
        checkb("drop_discard_valid", validD, 1'b0);
        check("drop_new_addr", imem_addr, 32'h200);
        idle(1);
        check("drop_instr", instrD, mem_word(32'h200));
        check("drop_pc4", pcplus4D, 32'h204);

        // Branch ignored while decode is stalled
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1);
        check("stallbr_pc4", pcplus4D, 32'h204);
        check("stallbr_addr", imem_addr, 32'h204);
        idle(1);
        check("stallbr_instr", instrD, mem_word(32'h204));
        check("stallbr_pc4_next", pcplus4D, 32'h208);
        check("stallbr_addr_next", imem_addr, 32'h208);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        idle(1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", pcplus4D, 32'h0);
        checkb("wrap_valid", validD, 1'b1);
        check("wrap_instr", instrD, mem_word(32'hFFFF_FFFC));

        // Randomized traffic: decode stalls imply fetch stalls, as from a hazard unit
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(299) == 0);
            r_sD  = ($urandom_range(5) == 0);
            r_sF  = r_sD | ($urandom_range(7) == 0);
            r_ps  = ($urandom_range(7) == 0);
            r_jp  = ($urandom_range(11) == 0);
            r_pb  = rand_target();
            r_pj  = rand_target();
            drive(r_rst, r_sF, r_sD, r_ps, r_pb, r_jp, r_pj,
                  ($urandom_range(9) == 0) ? 1 : 0);
        end
        idle(1);

        // Progress: the random phase must keep delivering instructions
        checks++;
        if (deliveries < 400) begin
            failures++;
            $display("FAIL liveness: got %0d deliveries expected at least 400", deliveries);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_fetch_stage.md
M_FETCH_STAGE -- requirements
Module: M_FETCH_STAGE

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port stallF, input, 1 bit: hold the PC; driven by the hazard unit.
REQ-005 SHALL have port stallD, input, 1 bit: hold the IF/ID register; driven by the hazard unit.
REQ-006 SHALL have port pcsrcD, input, 1 bit: branch taken, resolved in D.
REQ-007 SHALL have port pcbranchD, input, 32 bits: branch target.
REQ-008 SHALL have port jumpD, input, 1 bit: jump in D.
REQ-009 SHALL have port pcjumpD, input, 32 bits: jump target.
REQ-010 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-011 SHALL have port imem_addr, output, 32 bits: fetch address, equal to the PC.
REQ-012 SHALL have port imem_ready, input, 1 bit: imem_rdata is valid this cycle.
REQ-013 SHALL have port imem_rdata, input, 32 bits: fetched instruction.
REQ-014 SHALL have ports instrD (output, 32 bits), pcplus4D (output, 32 bits) and validD (output, 1 bit): the IF/ID register contents.

Function
REQ-015 SHALL implement an FSM with states FETCH, BUFFERED and DROP.
REQ-016 SHALL drive imem_req=1 only in FETCH and DROP, and SHALL hold imem_addr stable while imem_req=1 and imem_ready=0.
REQ-017 SHALL define redirect = (pcsrcD|jumpD) & ~stallD, with target = jumpD ? pcjumpD : pcbranchD (jump has priority).
REQ-018 On redirect, SHALL load a bubble into IF/ID (instrD=0, validD=0, pcplus4D=0) on the next edge, regardless of imem_ready.
REQ-019 In FETCH with imem_ready=1, ~stallF and no redirect, SHALL update PC<=PC+4 and IF/ID<={imem_rdata, PC+4, 1}, and stay in FETCH; latency from request to IF/ID is 1 edge after ready.
REQ-020 In FETCH with imem_ready=1 and stallF=1, SHALL capture imem_rdata and PC+4 into a one-entry buffer and move to BUFFERED; the PC holds.
REQ-021 In BUFFERED, SHALL keep imem_req=0. When ~stallF and ~stallD, SHALL transfer the buffer to IF/ID, set PC<=PC+4 and return to FETCH.
REQ-022 In BUFFERED with a redirect, SHALL discard the buffer, set PC<=target and return to FETCH.
REQ-023 In FETCH with a redirect and imem_ready=0, SHALL latch target into a pending register and move to DROP; the PC and imem_addr hold.
REQ-024 In FETCH with a redirect and imem_ready=1, SHALL discard the response, set PC<=target and stay in FETCH.
REQ-025 In DROP, SHALL discard the response on imem_ready=1, then set PC<=pending and return to FETCH. A second redirect in DROP SHALL overwrite pending (last wins).
REQ-026 When no instruction is delivered and ~stallD, SHALL load a bubble into IF/ID (instruction-memory wait inserts NOPs).
REQ-027 When stallD=1, SHALL hold IF/ID unchanged and ignore pcsrcD/jumpD.
REQ-028 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-029 While reset=1, SHALL set PC=RESET_PC, state=FETCH, imem_req=0, instrD=0, pcplus4D=0, validD=0, buffer and pending cleared. The first request SHALL occur in the first cycle after reset deasserts.
REQ-030 Reset asserted in BUFFERED or DROP SHALL abandon the held data; any imem response during reset SHALL be ignored.

Structure
REQ-031 SHALL place the FSM state encoding, the NOP encoding (32'h0) and the PC increment (4) in the shared pipeline package.
REQ-032 SHALL instantiate the IF/ID register as one sub-module, M_IFID_REG, with enable (~stallD) and clear (bubble) inputs; the PC and FSM SHALL stay in the top module.

Verification
REQ-033 Reset, RESET_PC=0, imem_ready always 1 -> imem_addr sequence 0, 4, 8; validD=1 from the 2nd cycle after reset, with pcplus4D=4, 8, 12.
REQ-034 stallF=stallD=1 for 3 cycles while ready arrives at addr 0x10 -> state BUFFERED, imem_req=0; after release, instrD=the 0x10 word, then the next fetch is at 0x14.
REQ-035 pcsrcD=1, pcbranchD=0x100 with ready=1 -> next edge: validD=0, imem_addr=0x100, then instrD=the word at 0x100.
REQ-036 jumpD=1 (pcjumpD=0x200) while the fetch at 0x20 waits 3 cycles -> DROP; the 0x20 data never reaches IF/ID; the next request is at 0x200.
REQ-037 pcsrcD=1 together with stallD=1 -> no redirect, and IF/ID holds.
REQ-038 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000 and pcplus4D=0.
